// File: rtl/alu_issue_stage.sv
// alu_issue_stage: execute-stage front end for the 32-bit ALU.
// Decodes RV32I R/I-type ALU ops into the ALU's 3-bit control code,
// selects operand b, and buffers legal ops in a 2-entry in-order FIFO.
// Undecodable ops are consumed, dropped, and counted.
//
// Ports:
//   clk, rst_n        - clock, async active-low reset
//   flush             - sync discard of all buffered ops
//   in_valid/in_ready - upstream handshake (in_ready = !full && !flush)
//   in_is_rtype, in_funct3, in_funct7b5 - decoded instruction fields
//   in_rs1, in_rs2, in_imm, in_tag      - operands and sideband tag
//   out_valid/out_ready - ALU-side handshake on the head entry
//   a, b, ALUControl, out_tag           - head entry toward the ALU
//   illegal, illegal_count              - reject pulse and saturating count
module alu_issue_stage #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_is_rtype,
  input  logic [2:0]       in_funct3,
  input  logic             in_funct7b5,
  input  logic [WIDTH-1:0] in_rs1,
  input  logic [WIDTH-1:0] in_rs2,
  input  logic [WIDTH-1:0] in_imm,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [2:0]       ALUControl,
  output logic [TAG_W-1:0] out_tag,
  output logic             illegal,
  output logic [7:0]       illegal_count
);

  localparam int unsigned CTL_W = 3;
  localparam int unsigned CNT_W = 8;

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [CTL_W-1:0] ctl;
    logic [TAG_W-1:0] tag;
  } entry_t;

  // r_head drives the ALU outputs directly; r_skid is the second slot.
  entry_t           r_head;
  entry_t           r_skid;
  logic [1:0]       r_count;
  logic             r_illegal;
  logic [CNT_W-1:0] r_illegal_count;

  logic [CTL_W-1:0] w_ctl;
  logic             w_illegal;
  logic             w_shift;
  logic [WIDTH-1:0] w_b;
  entry_t           w_entry;
  logic             w_accept;
  logic             w_push;
  logic             w_pop;

  // funct3/funct7[5] -> ALU control decode and legality check
  always_comb begin
    w_ctl     = 3'b000;
    w_illegal = 1'b0;
    w_shift   = 1'b0;
    case (in_funct3)
      3'b000: w_ctl = (in_is_rtype && in_funct7b5) ? 3'b001 : 3'b000;
      3'b001: begin
        w_ctl     = 3'b011;
        w_shift   = 1'b1;
        w_illegal = !in_is_rtype && in_funct7b5;
      end
      3'b010: w_ctl = 3'b111;
      3'b101: begin
        w_shift = 1'b1;
        // srl has no ALU code; only sra is executable
        if (in_funct7b5) w_ctl = 3'b100;
        else             w_illegal = 1'b1;
      end
      3'b110: w_ctl = 3'b110;
      3'b111: w_ctl = 3'b101;
      default: w_illegal = 1'b1;  // sltu, xor
    endcase
  end

  // Operand b: rs2, full immediate, or shamt field for immediate shifts
  always_comb begin
    if (in_is_rtype)  w_b = in_rs2;
    else if (w_shift) w_b = WIDTH'(in_imm[4:0]);
    else              w_b = in_imm;
  end

  always_comb begin
    w_entry.a   = in_rs1;
    w_entry.b   = w_b;
    w_entry.ctl = w_ctl;
    w_entry.tag = in_tag;
  end

  assign in_ready = (r_count != 2'd2) && !flush;
  assign w_accept = in_valid && in_ready;
  assign w_push   = w_accept && !w_illegal;
  assign w_pop    = out_valid && out_ready;

  // FIFO occupancy, reject pulse and saturating reject counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head          <= '0;
      r_skid          <= '0;
      r_count         <= 2'd0;
      r_illegal       <= 1'b0;
      r_illegal_count <= '0;
    end else begin
      r_illegal <= w_accept && w_illegal;
      if (w_accept && w_illegal && (r_illegal_count != {CNT_W{1'b1}}))
        r_illegal_count <= r_illegal_count + CNT_W'(1);

      if (flush) begin
        r_count <= 2'd0;
      end else begin
        case (r_count)
          2'd0: begin
            if (w_push) begin
              r_head  <= w_entry;
              r_count <= 2'd1;
            end
          end
          2'd1: begin
            if (w_push && w_pop) begin
              r_head <= w_entry;
            end else if (w_push) begin
              r_skid  <= w_entry;
              r_count <= 2'd2;
            end else if (w_pop) begin
              r_count <= 2'd0;
            end
          end
          2'd2: begin
            // in_ready is low when full, so only a pop can happen here
            if (w_pop) begin
              r_head  <= r_skid;
              r_count <= 2'd1;
            end
          end
          default: r_count <= 2'd0;
        endcase
      end
    end
  end

  assign out_valid     = (r_count != 2'd0);
  assign a             = r_head.a;
  assign b             = r_head.b;
  assign ALUControl    = r_head.ctl;
  assign out_tag       = r_head.tag;
  assign illegal       = r_illegal;
  assign illegal_count = r_illegal_count;

endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage: directed self-checking bench for alu_issue_stage.
module tb_alu_issue_stage;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned TAG_W = 5;

  logic             clk;
  logic             rst_n;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic             in_is_rtype;
  logic [2:0]       in_funct3;
  logic             in_funct7b5;
  logic [WIDTH-1:0] in_rs1;
  logic [WIDTH-1:0] in_rs2;
  logic [WIDTH-1:0] in_imm;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       ALUControl;
  logic [TAG_W-1:0] out_tag;
  logic             illegal;
  logic [7:0]       illegal_count;

  int n_tests;
  int n_fail;

  alu_issue_stage #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_is_rtype(in_is_rtype), .in_funct3(in_funct3), .in_funct7b5(in_funct7b5),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .a(a), .b(b), .ALUControl(ALUControl), .out_tag(out_tag),
    .illegal(illegal), .illegal_count(illegal_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rt, input logic [2:0] f3, input logic f7,
                       input logic [31:0] rs1, input logic [31:0] rs2,
                       input logic [31:0] imm, input logic [4:0] tag);
    in_valid    = 1'b1;
    in_is_rtype = rt;
    in_funct3   = f3;
    in_funct7b5 = f7;
    in_rs1      = rs1;
    in_rs2      = rs2;
    in_imm      = imm;
    in_tag      = tag;
  endtask

  task automatic check_head(input string tag, input logic [31:0] ea, input logic [31:0] eb,
                            input logic [2:0] ec, input logic [4:0] et);
    check_eq({tag, ".valid"}, 32'(out_valid), 32'd1);
    check_eq({tag, ".a"}, a, ea);
    check_eq({tag, ".b"}, b, eb);
    check_eq({tag, ".ctl"}, 32'(ALUControl), 32'(ec));
    check_eq({tag, ".tag"}, 32'(out_tag), 32'(et));
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_is_rtype = 1'b0; in_funct3 = 3'd0; in_funct7b5 = 1'b0;
    in_rs1 = '0; in_rs2 = '0; in_imm = '0; in_tag = '0;
    #1;
    check_eq("rst.valid", 32'(out_valid), 32'd0);
    check_eq("rst.a", a, 32'd0);
    check_eq("rst.ctl", 32'(ALUControl), 32'd0);
    check_eq("rst.cnt", 32'(illegal_count), 32'd0);
    check_eq("rst.illegal", 32'(illegal), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_eq("rst.in_ready", 32'(in_ready), 32'd1);
    tick();

    // R-type add
    out_ready = 1'b1;
    drive(1'b1, 3'b000, 1'b0, 32'd15, 32'd10, 32'd0, 5'd3);
    tick();
    in_valid = 1'b0;
    check_head("add", 32'd15, 32'd10, 3'b000, 5'd3);
    tick();
    check_eq("add.drain", 32'(out_valid), 32'd0);

    // sub followed back-to-back by srai
    drive(1'b1, 3'b000, 1'b1, 32'd20, 32'd50, 32'd0, 5'd4);
    tick();
    check_head("sub", 32'd20, 32'd50, 3'b001, 5'd4);
    drive(1'b0, 3'b101, 1'b1, 32'h8000_0000, 32'd9, 32'h0000_0402, 5'd5);
    tick();
    check_head("srai", 32'h8000_0000, 32'd2, 3'b100, 5'd5);
    // addi ignores f7b5 and takes the full immediate; slti -> slt
    drive(1'b0, 3'b000, 1'b1, 32'd7, 32'd9, 32'hFFFF_FFF0, 5'd6);
    tick();
    check_head("addi", 32'd7, 32'hFFFF_FFF0, 3'b000, 5'd6);
    drive(1'b0, 3'b010, 1'b0, 32'd1, 32'd9, 32'h0000_0123, 5'd7);
    tick();
    check_head("slti", 32'd1, 32'h0000_0123, 3'b111, 5'd7);
    drive(1'b0, 3'b001, 1'b0, 32'd1, 32'd9, 32'h0000_0FE3, 5'd8);
    tick();
    check_head("slli", 32'd1, 32'd3, 3'b011, 5'd8);
    in_valid = 1'b0;
    tick();
    check_eq("seq.drain", 32'(out_valid), 32'd0);

    // Backpressure: three ops with out_ready low
    out_ready = 1'b0;
    drive(1'b1, 3'b000, 1'b0, 32'd1, 32'd2, 32'd0, 5'd1);
    tick();
    drive(1'b1, 3'b110, 1'b0, 32'd3, 32'd4, 32'd0, 5'd2);
    tick();
    check_eq("bp.full_ready", 32'(in_ready), 32'd0);
    drive(1'b1, 3'b111, 1'b0, 32'd5, 32'd6, 32'd0, 5'd3);
    tick();
    check_head("bp.hold", 32'd1, 32'd2, 3'b000, 5'd1);
    check_eq("bp.still_full", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    // Pop while full: in_ready stays low, so op3 waits a cycle
    tick();
    check_head("bp.op2", 32'd3, 32'd4, 3'b110, 5'd2);
    check_eq("bp.ready_back", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    check_head("bp.op3", 32'd5, 32'd6, 3'b101, 5'd3);
    tick();
    check_eq("bp.drain", 32'(out_valid), 32'd0);

    // Illegal: xor then slli with f7b5=1
    drive(1'b1, 3'b100, 1'b0, 32'd1, 32'd2, 32'd0, 5'd9);
    tick();
    check_eq("ill1.valid", 32'(out_valid), 32'd0);
    check_eq("ill1.pulse", 32'(illegal), 32'd1);
    check_eq("ill1.cnt", 32'(illegal_count), 32'd1);
    drive(1'b0, 3'b001, 1'b1, 32'd1, 32'd2, 32'h0000_0401, 5'd9);
    tick();
    in_valid = 1'b0;
    check_eq("ill2.valid", 32'(out_valid), 32'd0);
    check_eq("ill2.pulse", 32'(illegal), 32'd1);
    check_eq("ill2.cnt", 32'(illegal_count), 32'd2);
    tick();
    check_eq("ill.pulse_end", 32'(illegal), 32'd0);
    // srl is illegal too
    drive(1'b1, 3'b101, 1'b0, 32'd1, 32'd2, 32'd0, 5'd9);
    tick();
    in_valid = 1'b0;
    check_eq("srl.cnt", 32'(illegal_count), 32'd3);
    check_eq("srl.valid", 32'(out_valid), 32'd0);

    // Saturation: 300 sltu ops
    drive(1'b1, 3'b011, 1'b0, 32'd1, 32'd2, 32'd0, 5'd0);
    repeat (251) tick();
    check_eq("sat.254", 32'(illegal_count), 32'd254);
    tick();
    check_eq("sat.255", 32'(illegal_count), 32'd255);
    repeat (48) tick();
    in_valid = 1'b0;
    check_eq("sat.hold", 32'(illegal_count), 32'd255);
    check_eq("sat.valid", 32'(out_valid), 32'd0);
    tick();

    // Flush with two entries buffered
    out_ready = 1'b0;
    drive(1'b1, 3'b000, 1'b0, 32'd11, 32'd12, 32'd0, 5'd7);
    tick();
    drive(1'b1, 3'b000, 1'b0, 32'd13, 32'd14, 32'd0, 5'd8);
    tick();
    check_eq("fl.pre_valid", 32'(out_valid), 32'd1);
    flush = 1'b1;
    drive(1'b1, 3'b000, 1'b0, 32'd99, 32'd99, 32'd0, 5'd1);
    check_eq("fl.in_ready", 32'(in_ready), 32'd0);
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    check_eq("fl.valid", 32'(out_valid), 32'd0);
    check_eq("fl.cnt", 32'(illegal_count), 32'd255);
    out_ready = 1'b1;
    drive(1'b1, 3'b110, 1'b0, 32'hAAAA_5555, 32'h5555_AAAA, 32'd0, 5'd10);
    tick();
    in_valid = 1'b0;
    check_head("fl.or", 32'hAAAA_5555, 32'h5555_AAAA, 3'b110, 5'd10);
    tick();

    // Async reset mid-stream with two entries buffered
    out_ready = 1'b0;
    drive(1'b1, 3'b111, 1'b0, 32'h1234_5678, 32'h0F0F_0F0F, 32'd0, 5'd17);
    tick();
    drive(1'b1, 3'b010, 1'b0, 32'd5, 32'd6, 32'd0, 5'd18);
    tick();
    in_valid = 1'b0;
    check_eq("ar.pre_valid", 32'(out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("ar.valid", 32'(out_valid), 32'd0);
    check_eq("ar.a", a, 32'd0);
    check_eq("ar.b", b, 32'd0);
    check_eq("ar.ctl", 32'(ALUControl), 32'd0);
    check_eq("ar.tag", 32'(out_tag), 32'd0);
    check_eq("ar.cnt", 32'(illegal_count), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_issue_stage.md
# alu_issue_stage

- Execute-stage front end that drives the 32-bit ALU's operand/control interface.
- Accepts decoded RV32I integer instructions (R-type and I-type ALU ops) over a valid/ready handshake and maps funct3/funct7[5] onto the ALU's 3-bit ALUControl encoding.
- Selects operand b (rs2 or immediate) and buffers issued operations in a 2-entry skid FIFO toward the ALU side.
- Rejects encodings the ALU cannot execute; each rejection raises a one-cycle pulse and increments a saturating counter.

## Interface

Parameters:
- WIDTH, 32, operand width
- TAG_W, 5, width of sideband tag (destination register) carried with each op

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset
- flush  input  1  synchronous; discards all buffered ops
- in_valid  input  1  upstream op present
- in_ready  output  1  stage can accept; = !full && !flush
- in_is_rtype  input  1  1 = R-type (b from rs2), 0 = I-type (b from imm)
- in_funct3  input  3  instruction funct3
- in_funct7b5  input  1  instruction bit 30
- in_rs1  input  WIDTH  rs1 data
- in_rs2  input  WIDTH  rs2 data
- in_imm  input  WIDTH  sign-extended immediate
- in_tag  input  TAG_W  sideband tag
- out_valid  output  1  head entry valid toward ALU
- out_ready  input  1  ALU side consumes head
- a  output  WIDTH  ALU operand a
- b  output  WIDTH  ALU operand b
- ALUControl  output  3  ALU op code
- out_tag  output  TAG_W  tag of head entry
- illegal  output  1  one-cycle pulse on rejected op
- illegal_count  output  8  saturating count of rejected ops

## Operation

ALUControl encoding: 000 add, 001 sub, 010 not, 011 sll, 100 sra, 101 and, 110 or, 111 slt. The not code (010) is never produced by this block.

Decode on an accepted op (in_valid && in_ready):
- f3=000: R-type with f7b5=1 -> 001; otherwise -> 000. I-type ignores f7b5.
- f3=001: -> 011. An I-type op with f7b5=1 is illegal.
- f3=010: -> 111.
- f3=101 with f7b5=1: -> 100.
- f3=110: -> 110.
- f3=111: -> 101.
- Illegal: f3=011 (sltu), f3=100 (xor), and f3=101 with f7b5=0 (srl).

Operands:
- a is always in_rs1.
- R-type: b = in_rs2.
- I-type, non-shift: b = in_imm.
- I-type shifts (f3=001/101): b = {27'b0, in_imm[4:0]}.

Illegal handling:
- The op is consumed (handshake completes) but is not written to the FIFO.
- illegal pulses high the following cycle.
- illegal_count increments and saturates at 255.

FIFO:
- 2 entries, in-order.
- Push on a legal accept; pop on out_valid && out_ready. Push and pop in the same cycle are both honoured.
- Full (2 entries): in_ready=0, even if a pop occurs that cycle.
- Empty: out_valid=0. a, b, ALUControl and out_tag hold their last values and are don't-care.

## Timing

- Reset (rst_n low, asynchronous): FIFO empty, out_valid=0, a=b=0, ALUControl=000, out_tag=0, illegal=0, illegal_count=0. in_ready=1 once rst_n is high and flush is low.
- Latency: an op accepted at edge N appears on out_valid/a/b/ALUControl after edge N (registered outputs, 1 cycle).
- Throughput: 1 op/cycle when out_ready is held high.
- Stability: while out_valid && !out_ready, a, b, ALUControl and out_tag are held stable.
- flush:
  - Empties the FIFO at the next edge and forces in_ready=0 that cycle; no accept occurs.
  - illegal_count is not cleared.
  - An illegal pulse already scheduled still fires.
- Reset asserted mid-operation: all buffered ops are lost immediately, with no output glitch beyond the async clear.

## Test plan

- R-type add: f3=000, f7b5=0, rs1=15, rs2=10, out_ready=1 -> next cycle out_valid=1, a=15, b=10, ALUControl=000.
- R-type sub and I-type shift:
  - f3=000, f7b5=1, rs1=20, rs2=50 -> ALUControl=001, b=50.
  - Then I-type f3=101, f7b5=1, imm=0x402 -> ALUControl=100, b=2.
- Backpressure: out_ready=0, three back-to-back ops -> in_ready drops after the 2nd accept; outputs hold op1. Raising out_ready drains op1 then op2 in order, with no loss.
- Illegal ops: f3=100 R-type, then I-type f3=001 f7b5=1 -> no out_valid, two illegal pulses, illegal_count=2. Feed 300 illegal ops -> illegal_count=255.
- Flush with 2 entries buffered -> out_valid=0 next cycle. Subsequent op f3=110, rs1=0xAAAA5555, rs2=0x5555AAAA issues with ALUControl=110.
- Async reset asserted mid-stream with entries buffered -> out_valid=0 and all outputs zero immediately, before the next clock edge.
